uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - Receive side of the system UART: samples serial input rx, deframes 8N1 bytes (LSB first) and holds
//   the byte in a one-entry register readable over the same simple bus slave used by the transmitter.
// - Raises a one-cycle o_int per received byte; sits beside the transmitter on the peripheral bus.
// PARAMETERS
// - SYS_CLK   50_000_000  system clock frequency in Hz
// - BAUDRATE  115200      line rate; TICK = SYS_CLK/BAUDRATE clocks per bit (434 at defaults)
// PORTS
// - i_clk    in   1  system clock, all logic on rising edge
// - i_reset  in   1  asynchronous, active-low reset (0 = reset)
// - i_adr    in   1  register select: 0 = DATA, 1 = STATUS
// - o_dat    out  8  read data: DATA = received byte; STATUS = {5'b0, ferr, overrun, valid}
// - i_we     in   1  write strobe; writes are ignored by this block
// - i_cyc    in   1  bus cycle active
// - rx       in   1  asynchronous serial input, idle high
// - o_int    out  1  one-cycle pulse when a byte is latched into DATA
// BEHAVIOUR
// - Reset: state IDLE, baud counter 0, rx_data 8'h00, valid/overrun/ferr 0, o_int 0, sync flops 1.
// - rx passes a 2-flop synchronizer (rx_s); all decisions use rx_s only.
// - Baud counter width = $clog2(TICK+1); cleared on every state change, else increments.
// - FSM: IDLE -> START -> DATA0..DATA7 -> STOP -> IDLE.
//   IDLE : rx_s==0 -> START, counter cleared.
//   START: counter==TICK/2 -> rx_s==0: DATA0, counter cleared; rx_s==1: glitch, back to IDLE.
//   DATAn: counter==TICK-1 -> shift rx_s into bit n (LSB first), next state; sample at bit centre.
//   STOP : counter==TICK-1 -> sample stop bit, latch shift register, back to IDLE.
// - Latch (STOP exit): rx_data <= shift; valid <= 1; o_int high exactly that cycle;
//   overrun <= 1 if valid was already 1 (old byte lost, new byte kept).
// - Read: o_dat combinational from i_adr regardless of i_cyc. i_cyc && ~i_we && i_adr==0 clears valid;
//   i_cyc && ~i_we && i_adr==1 clears overrun and ferr (bits cleared after the read returns them).
// - Simultaneous DATA read and latch: latch wins; valid stays 1, overrun unchanged (no overrun).
// - Simultaneous STATUS read and overrun/ferr set: set wins.
// - Latency: o_int rises 9.5 bit times + 3 clocks (sync + latch) after falling edge of start bit.
// - Reset asserted mid-frame: immediate return to IDLE, partial byte discarded, no o_int.
// - rx held low (break): one byte 8'h00 with stop-bit error handling below, then waits for rx_s high
//   is not required; IDLE restarts on next low sample (back-to-back frames allowed, no idle gap needed).
// CONFIGURATION
// - UART_RX_FRAMING_CHECK_EN defined: stop bit sampled 0 -> byte discarded (valid, rx_data, overrun
//   untouched, no o_int), ferr <= 1. Undefined: stop bit not checked, byte always latched, ferr tied 0.
// STRUCTURE
// - uart_pkg: FSM state encodings (IDLE, START, DATA0..7, STOP), register addresses
//   (ADR_DATA=1'b0, ADR_STATUS=1'b1), STATUS bit indices, TICK computation function.
// - Sub-module uart_rx_sync: 2-flop synchronizer, async active-low reset to 1; reusable elsewhere.
// TESTING
// - Defaults (TICK=434); bench drives rx with its own bit timing; loopback with transmitter allowed.
// - Send 8'hA5 -> o_int one pulse after ~4123 clks; STATUS=8'h01; DATA read=8'hA5; then STATUS=8'h00.
// - Send 8'h3C then 8'hC3 without reading -> STATUS=8'h03, DATA=8'hC3; STATUS read -> 8'h01.
// - Low glitch of 100 clks on idle rx -> FSM returns IDLE, no o_int, STATUS stays 8'h00.
// - Assert i_reset low during DATA4 of a frame -> all outputs at reset values, no o_int; next frame
//   8'h5A received correctly.
// - Macro on: frame 8'h81 with stop bit 0 -> no o_int, STATUS=8'h04; macro off: o_int, DATA=8'h81.
// - DATA read in the same cycle as latch of 8'h77 -> valid stays 1, overrun 0, DATA=8'h77.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, register map and baud tick helper.
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_DATA0 = 4'd2,
    ST_DATA1 = 4'd3,
    ST_DATA2 = 4'd4,
    ST_DATA3 = 4'd5,
    ST_DATA4 = 4'd6,
    ST_DATA5 = 4'd7,
    ST_DATA6 = 4'd8,
    ST_DATA7 = 4'd9,
    ST_STOP  = 4'd10
  } rx_state_t;

  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  localparam int STAT_VALID   = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int STAT_FERR    = 2;

  function automatic int calc_tick(input int sys_clk, input int baudrate);
    return sys_clk / baudrate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Simple peripheral bus slave port shared by the UART blocks.
interface uart_rx_if;
  logic       i_adr;
  logic [7:0] o_dat;
  logic       i_we;
  logic       i_cyc;

  modport master (output i_adr, output i_we, output i_cyc, input  o_dat);
  modport slave  (input  i_adr, input  i_we, input  i_cyc, output o_dat);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; resets to 1 (idle line level).
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with one-entry DATA register and STATUS register on the peripheral bus.
// Optional stop-bit checking enabled by defining UART_RX_FRAMING_CHECK_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYS_CLK  = 50_000_000,
  parameter int BAUDRATE = 115200
) (
  input  logic           i_clk,
  input  logic           i_reset,
  uart_rx_if.slave       bus,
  input  logic           rx,
  output logic           o_int
);

  localparam int TICK = calc_tick(SYS_CLK, BAUDRATE);
  localparam int CW   = $clog2(TICK + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK - 1);

  rx_state_t   state;
  logic [CW-1:0] cnt;
  logic [7:0]  shift;
  logic [7:0]  rx_data;
  logic        valid;
  logic        overrun;
  logic        ferr;
  logic        rx_s;

  logic        stop_done;
  logic        latch;
  logic        ferr_set;
  logic        rd_data;
  logic        rd_status;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .d       (rx),
    .q       (rx_s)
  );

  assign stop_done = (state == ST_STOP) && (cnt == CNT_LAST);
  assign rd_data   = bus.i_cyc && !bus.i_we && (bus.i_adr == ADR_DATA);
  assign rd_status = bus.i_cyc && !bus.i_we && (bus.i_adr == ADR_STATUS);

`ifdef UART_RX_FRAMING_CHECK_EN
  assign latch    = stop_done && rx_s;
  assign ferr_set = stop_done && !rx_s;
`else
  assign latch    = stop_done;
  assign ferr_set = 1'b0;
`endif

  always_comb begin
    bus.o_dat = rx_data;
    if (bus.i_adr == ADR_STATUS) begin
      bus.o_dat               = 8'h00;
      bus.o_dat[STAT_VALID]   = valid;
      bus.o_dat[STAT_OVERRUN] = overrun;
      bus.o_dat[STAT_FERR]    = ferr;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      shift   <= 8'h00;
      rx_data <= 8'h00;
      valid   <= 1'b0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
      o_int   <= 1'b0;
    end else begin
      o_int <= latch;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            // a start bit that is gone by its centre was a glitch
            state <= rx_s ? ST_IDLE : ST_DATA0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            // shifting right leaves the first-received bit in bit 0 after eight samples
            shift <= {rx_s, shift[7:1]};
            state <= rx_state_t'(state + 4'd1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      if (latch) begin
        rx_data <= shift;
        valid   <= 1'b1;
      end else if (rd_data) begin
        valid <= 1'b0;
      end

      if (latch && valid && !rd_data) overrun <= 1'b1;
      else if (rd_status)              overrun <= 1'b0;

      if (ferr_set)       ferr <= 1'b1;
      else if (rd_status) ferr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default baud settings; follows UART_RX_FRAMING_CHECK_EN if defined.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int TICK = 434;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic o_int;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_cnt = 0;
  int int_cnt = 0;
  int int_cyc = 0;
  int t_start = 0;

  uart_rx_if bus ();

  uart_rx #(.SYS_CLK(50_000_000), .BAUDRATE(115200)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus),
    .rx      (rx),
    .o_int   (o_int)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (o_int) begin
      int_cnt <= int_cnt + 1;
      int_cyc <= cyc_cnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    t_start = cyc_cnt;
    rx = 1'b0;
    hold(TICK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(TICK);
    end
    rx = stop_bit;
    hold(TICK);
    rx = 1'b1;
  endtask

  task automatic peek(input logic adr, output logic [7:0] d);
    bus.i_adr = adr;
    @(negedge clk);
    d = bus.o_dat;
  endtask

  task automatic bus_rd(input logic adr, output logic [7:0] d);
    @(posedge clk);
    #1;
    bus.i_adr = adr;
    bus.i_we  = 1'b0;
    bus.i_cyc = 1'b1;
    @(negedge clk);
    d = bus.o_dat;
    @(posedge clk);
    #1;
    bus.i_cyc = 1'b0;
  endtask

  logic [7:0] d;
  int ic;

  initial begin
    bus.i_adr = ADR_DATA;
    bus.i_we  = 1'b0;
    bus.i_cyc = 1'b0;
    hold(5);
    peek(ADR_DATA, d);   chk("rst_data", d, 8'h00);
    peek(ADR_STATUS, d); chk("rst_status", d, 8'h00);
    chk("rst_int", o_int, 1'b0);
    rst_n = 1'b1;
    hold(20);

    // single byte
    ic = int_cnt;
    send_frame(8'hA5, 1'b1);
    chk("a5_int", int_cnt - ic, 1);
    chk("a5_lat_win", ((int_cyc - t_start) >= 4118) && ((int_cyc - t_start) <= 4132), 1);
    bus_rd(ADR_STATUS, d); chk("a5_status", d, 8'h01);
    bus_rd(ADR_DATA, d);   chk("a5_data", d, 8'hA5);
    peek(ADR_STATUS, d);   chk("a5_status_clr", d, 8'h00);

    // back-to-back frames without reading
    ic = int_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    chk("ovr_int", int_cnt - ic, 2);
    peek(ADR_STATUS, d);   chk("ovr_status", d, 8'h03);
    peek(ADR_DATA, d);     chk("ovr_data", d, 8'hC3);
    bus_rd(ADR_STATUS, d); chk("ovr_status_rd", d, 8'h03);
    peek(ADR_STATUS, d);   chk("ovr_status_after", d, 8'h01);
    bus_rd(ADR_DATA, d);   chk("ovr_data_rd", d, 8'hC3);
    peek(ADR_STATUS, d);   chk("ovr_status_empty", d, 8'h00);

    // short low glitch on the idle line
    ic = int_cnt;
    rx = 1'b0;
    hold(100);
    rx = 1'b1;
    hold(600);
    chk("glitch_int", int_cnt - ic, 0);
    peek(ADR_STATUS, d); chk("glitch_status", d, 8'h00);

    // DATA read landing exactly on the latch cycle of 8'h77, with an unread byte pending
    ic = int_cnt;
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(posedge clk);
        repeat (4126) @(posedge clk);
        #1;
        bus.i_adr = ADR_DATA;
        bus.i_we  = 1'b0;
        bus.i_cyc = 1'b1;
        @(posedge clk);
        #1;
        bus.i_cyc = 1'b0;
      end
    join
    chk("coll_int", int_cnt - ic, 2);
    peek(ADR_STATUS, d); chk("coll_status", d, 8'h01);
    peek(ADR_DATA, d);   chk("coll_data", d, 8'h77);

    // reset in the middle of DATA4 of a frame, with a byte still pending
    ic = int_cnt;
    @(posedge clk);
    #1;
    rx = 1'b0;
    hold(TICK);
    for (int i = 0; i < 4; i++) hold(TICK);
    hold(TICK / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    hold(5);
    peek(ADR_DATA, d);   chk("mrst_data", d, 8'h00);
    peek(ADR_STATUS, d); chk("mrst_status", d, 8'h00);
    chk("mrst_int_pin", o_int, 1'b0);
    rst_n = 1'b1;
    hold(2 * TICK);
    chk("mrst_int", int_cnt - ic, 0);
    send_frame(8'h5A, 1'b1);
    chk("mrst_next_int", int_cnt - ic, 1);
    bus_rd(ADR_DATA, d); chk("mrst_next_data", d, 8'h5A);
    peek(ADR_STATUS, d); chk("mrst_next_status", d, 8'h00);

    // stop bit sampled low
    ic = int_cnt;
    send_frame(8'h81, 1'b0);
    hold(20);
`ifdef UART_RX_FRAMING_CHECK_EN
    chk("ferr_int", int_cnt - ic, 0);
    peek(ADR_STATUS, d);   chk("ferr_status", d, 8'h04);
    peek(ADR_DATA, d);     chk("ferr_data_kept", d, 8'h5A);
    bus_rd(ADR_STATUS, d); chk("ferr_status_rd", d, 8'h04);
    peek(ADR_STATUS, d);   chk("ferr_status_clr", d, 8'h00);
`else
    chk("ferr_int", int_cnt - ic, 1);
    peek(ADR_STATUS, d); chk("ferr_status", d, 8'h01);
    bus_rd(ADR_DATA, d); chk("ferr_data", d, 8'h81);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
